// File: rtl/mist_spi_master_if.sv
// Request/response bundle for mist_spi_master.
// master: byte requester; slave: the SPI engine.
interface mist_spi_master_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] target;
  logic       cs_hold;
  logic       cs_release;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  modport master (
    output tx_data, tx_valid, target,
    output cs_hold, cs_release,
    input  tx_ready, rx_data, rx_valid,
    input  busy
  );

  modport slave (
    input  tx_data, tx_valid, target,
    input  cs_hold, cs_release,
    output tx_ready, rx_data, rx_valid,
    output busy
  );
endinterface

// File: rtl/mist_spi_master.sv
// MiST SPI mode-0 byte master with four active-low selects.
// Ports: CLOCK_50/RESET, bus (tx/rx handshake), SPI_SCK/DI/DO,
// CONF_DATA0, SPI_SS2, SPI_SS3, SPI_SS4 (MIST_SPI_MASTER_SS4_EN).
module mist_spi_master #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic CLOCK_50,
  input  logic RESET,
  mist_spi_master_if.slave bus,
  output logic SPI_SCK,
  output logic SPI_DI,
  input  logic SPI_DO,
  output logic CONF_DATA0,
  output logic SPI_SS2,
  output logic SPI_SS3
`ifdef MIST_SPI_MASTER_SS4_EN
  ,
  output logic SPI_SS4
`endif
);

`ifdef MIST_SPI_MASTER_SS4_EN
  localparam int NSEL = 4;
`else
  localparam int NSEL = 3;
`endif

  localparam logic [7:0] HALF = 8'(CLKDIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    GAP
  } state_e;

  // Without SS4, target 11 yields no select (dummy clocks).
  function automatic logic [NSEL-1:0] sel_n(
    input logic [1:0] tgt
  );
    logic [NSEL-1:0] r;
    for (int i = 0; i < NSEL; i++) begin
      r[i] = (tgt != 2'(i));
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      rsh_q, rsh_d;
  logic [7:0]      rxd_q, rxd_d;
  logic            rxv_q, rxv_d;
  logic            sck_q, sck_d;
  logic            di_q, di_d;
  logic [NSEL-1:0] cs_n_q, cs_n_d;
  logic [1:0]      tgt_q, tgt_d;
  logic            hold_q, hold_d;
  logic            held_q, held_d;
  logic            pend_q, pend_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rsh_d   = rsh_q;
    rxd_d   = rxd_q;
    rxv_d   = 1'b0;
    sck_d   = sck_q;
    di_d    = di_q;
    cs_n_d  = cs_n_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    held_d  = held_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (bus.tx_valid) begin
          sh_d   = bus.tx_data;
          tgt_d  = bus.target;
          hold_d = bus.cs_hold;
          held_d = 1'b0;
          cnt_d  = HALF;
          if (held_q && bus.target != tgt_q) begin
            // Retarget: deselect first, byte waits in sh_q.
            state_d = GAP;
            cs_n_d  = '1;
            pend_d  = 1'b1;
          end else begin
            state_d = SHIFT_LO;
            bit_d   = 3'd0;
            cs_n_d  = sel_n(bus.target);
            di_d    = bus.tx_data[7];
          end
        end else if (bus.cs_release && held_q) begin
          state_d = GAP;
          cnt_d   = HALF;
          cs_n_d  = '1;
          held_d  = 1'b0;
        end
      end
      SHIFT_LO: begin
        if (cnt_q == 8'd0) begin
          state_d = SHIFT_HI;
          cnt_d   = HALF;
          sck_d   = 1'b1;
          rsh_d   = {rsh_q[6:0], SPI_DO};
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SHIFT_HI: begin
        if (cnt_q == 8'd0) begin
          sck_d = 1'b0;
          cnt_d = HALF;
          if (bit_q != 3'd7) begin
            state_d = SHIFT_LO;
            bit_d   = bit_q + 3'd1;
            sh_d    = {sh_q[6:0], 1'b0};
            di_d    = sh_q[6];
          end else begin
            rxd_d = rsh_q;
            rxv_d = 1'b1;
            if (hold_q) begin
              state_d = IDLE;
              held_d  = 1'b1;
            end else begin
              state_d = GAP;
              cs_n_d  = '1;
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          if (pend_q) begin
            state_d = SHIFT_LO;
            cnt_d   = HALF;
            bit_d   = 3'd0;
            cs_n_d  = sel_n(tgt_q);
            di_d    = sh_q[7];
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      rsh_q   <= 8'd0;
      rxd_q   <= 8'd0;
      rxv_q   <= 1'b0;
      sck_q   <= 1'b0;
      di_q    <= 1'b0;
      cs_n_q  <= '1;
      tgt_q   <= 2'd0;
      hold_q  <= 1'b0;
      held_q  <= 1'b0;
      pend_q  <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rsh_q   <= rsh_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
      sck_q   <= sck_d;
      di_q    <= di_d;
      cs_n_q  <= cs_n_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
      held_q  <= held_d;
      pend_q  <= pend_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tx_ready = rdy_q;
  assign bus.rx_data  = rxd_q;
  assign bus.rx_valid = rxv_q;
  assign bus.busy     = busy_q;
  assign SPI_SCK      = sck_q;
  assign SPI_DI       = di_q;
  assign CONF_DATA0   = cs_n_q[0];
  assign SPI_SS2      = cs_n_q[1];
  assign SPI_SS3      = cs_n_q[2];
`ifdef MIST_SPI_MASTER_SS4_EN
  assign SPI_SS4      = cs_n_q[3];
`endif

endmodule

// File: tb/tb_mist_spi_master.sv
// Self-checking bench for mist_spi_master (CLKDIV 2 and 1).
// Table of byte transfers plus release/priority/reset sequences.
module tb_mist_spi_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sel;
  logic       tx_valid, cs_release, cs_hold;
  logic [1:0] target, miso_mode;
  logic [7:0] tx_data;
  logic       rel_also;

  mist_spi_master_if if0();
  mist_spi_master_if if1();

  assign if0.tx_data    = tx_data;
  assign if0.target     = target;
  assign if0.cs_hold    = cs_hold;
  assign if0.tx_valid   = tx_valid & ~sel;
  assign if0.cs_release = cs_release & ~sel;
  assign if1.tx_data    = tx_data;
  assign if1.target     = target;
  assign if1.cs_hold    = cs_hold;
  assign if1.tx_valid   = tx_valid & sel;
  assign if1.cs_release = cs_release & sel;

  logic sck0, di0, do0, c00, s20, s30;
  logic sck1, di1, do1, c01, s21, s31;
  logic s40, s41;

  assign do0 = (miso_mode == 2'd0) ? di0 : miso_mode[0];
  assign do1 = (miso_mode == 2'd0) ? di1 : miso_mode[0];

  mist_spi_master #(.CLKDIV(2)) u0 (
    .CLOCK_50(clk), .RESET(rst), .bus(if0),
    .SPI_SCK(sck0), .SPI_DI(di0), .SPI_DO(do0),
    .CONF_DATA0(c00), .SPI_SS2(s20), .SPI_SS3(s30)
`ifdef MIST_SPI_MASTER_SS4_EN
    , .SPI_SS4(s40)
`endif
  );

  mist_spi_master #(.CLKDIV(1)) u1 (
    .CLOCK_50(clk), .RESET(rst), .bus(if1),
    .SPI_SCK(sck1), .SPI_DI(di1), .SPI_DO(do1),
    .CONF_DATA0(c01), .SPI_SS2(s21), .SPI_SS3(s31)
`ifdef MIST_SPI_MASTER_SS4_EN
    , .SPI_SS4(s41)
`endif
  );

`ifndef MIST_SPI_MASTER_SS4_EN
  assign s40 = 1'b1;
  assign s41 = 1'b1;
`endif

  logic       sck, rxv, rdy, bsy;
  logic [7:0] rxd;
  logic [3:0] csn;

  always_comb begin
    if (sel) begin
      sck = sck1; rxv = if1.rx_valid;
      rdy = if1.tx_ready; bsy = if1.busy;
      rxd = if1.rx_data;
      csn = {s41, s31, s21, c01};
    end else begin
      sck = sck0; rxv = if0.rx_valid;
      rdy = if0.tx_ready; bsy = if0.busy;
      rxd = if0.rx_data;
      csn = {s40, s30, s20, c00};
    end
  end

  int vec_n = 0;
  int err_n = 0;
  logic [7:0] exp_q[$];

  task automatic check(string name, int act, int exp);
    vec_n++;
    if (act != exp) begin
      err_n++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && rxv === 1'b1) begin
      if (exp_q.size() == 0)
        check("rx_spurious", int'(rxv), 0);
      else
        check("rx_data", int'(rxd), int'(exp_q.pop_front()));
    end
  end

  function automatic logic [3:0] exp_cs(logic [1:0] t);
    logic [3:0] r;
    r = 4'hF;
`ifndef MIST_SPI_MASTER_SS4_EN
    if (t == 2'd3) return r;
`endif
    r[t] = 1'b0;
    return r;
  endfunction

  task automatic run_byte(bit s, logic [1:0] tgt,
                          logic [7:0] data, bit hold,
                          logic [1:0] mode, bit pre,
                          int held);
    int d, start, nv, last;
    int rises, first_rise, bad_cs, bad_rdy;
    int nrxv, rxv_at;
    logic prev;
    logic [3:0] e;
    @(negedge clk);
    sel = s;
    d = s ? 1 : 2;
    miso_mode = mode;
    tx_data = data;
    target = tgt;
    cs_hold = hold;
    tx_valid = 1'b1;
    cs_release = rel_also;
    #1;
    check("tx_ready_pre", int'(rdy), 1);
    if (held >= 0)
      check("held_cs", int'(csn), int'(exp_cs(2'(held))));
    exp_q.push_back(mode == 2'd0 ? data :
                    mode == 2'd1 ? 8'hFF : 8'h00);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    cs_release = 1'b0;
    start = 1 + (pre ? d : 0);
    nv = start + 16 * d;
    last = hold ? nv : nv + d;
    rises = 0; first_rise = 0; bad_cs = 0;
    bad_rdy = 0; nrxv = 0; rxv_at = 0; prev = 1'b0;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      if (n < start) e = 4'hF;
      else if (n < nv || hold) e = exp_cs(tgt);
      else e = 4'hF;
      if (csn !== e) bad_cs++;
      if (rdy !== (n == last) || bsy !== (n != last))
        bad_rdy++;
      if (sck && !prev) begin
        rises++;
        if (rises == 1) first_rise = n;
      end
      prev = sck;
      if (rxv) begin
        nrxv++;
        rxv_at = n;
      end
    end
    check("cs_pattern", bad_cs, 0);
    check("ready_busy", bad_rdy, 0);
    check("sck_rises", rises, 8);
    check("first_rise", first_rise, start + d);
    check("rxv_count", nrxv, 1);
    check("rxv_cycle", rxv_at, nv);
    check("sck_low_end", int'(sck), 0);
  endtask

  typedef struct {
    bit         s;
    logic [1:0] tgt;
    logic [7:0] data;
    bit         hold;
    logic [1:0] mode;
    bit         pre;
    int         held;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int rises;
    logic prev;
    tbl[0] = '{0, 2'd0, 8'hA5, 0, 2'd0, 0, -1};
    tbl[1] = '{0, 2'd1, 8'h12, 1, 2'd0, 0, -1};
    tbl[2] = '{0, 2'd1, 8'h34, 0, 2'd0, 0, 1};
    tbl[3] = '{0, 2'd2, 8'hC3, 1, 2'd2, 0, -1};
    tbl[4] = '{0, 2'd1, 8'h5A, 0, 2'd0, 1, 2};
    tbl[5] = '{1, 2'd0, 8'h00, 0, 2'd1, 0, -1};
    tbl[6] = '{1, 2'd3, 8'h69, 0, 2'd0, 0, -1};
    tbl[7] = '{1, 2'd2, 8'h81, 0, 2'd0, 0, -1};
    tbl[8] = '{0, 2'd3, 8'hF0, 0, 2'd1, 0, -1};

    rst = 1'b1; sel = 1'b0; tx_valid = 1'b0;
    cs_release = 1'b0; cs_hold = 1'b0;
    target = 2'd0; tx_data = 8'd0;
    miso_mode = 2'd0; rel_also = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sel = i[0];
      #1;
      check("rst_sck", int'(sck), 0);
      check("rst_cs", int'(csn), 15);
      check("rst_rxd", int'(rxd), 0);
      check("rst_rxv", int'(rxv), 0);
      check("rst_busy", int'(bsy), 0);
      check("rst_ready", int'(rdy), 1);
    end

    for (int i = 0; i < 9; i++)
      run_byte(tbl[i].s, tbl[i].tgt, tbl[i].data,
               tbl[i].hold, tbl[i].mode, tbl[i].pre,
               tbl[i].held);

    run_byte(0, 2'd0, 8'h3C, 1, 2'd0, 0, -1);
    @(negedge clk);
    cs_release = 1'b1;
    @(posedge clk);
    #1 cs_release = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      check("rel_cs", int'(csn), 15);
      check("rel_ready", int'(rdy), n == 3 ? 1 : 0);
      check("rel_busy", int'(bsy), n == 3 ? 0 : 1);
    end

    run_byte(0, 2'd2, 8'h77, 1, 2'd0, 0, -1);
    rel_also = 1'b1;
    run_byte(0, 2'd2, 8'h88, 0, 2'd0, 0, 2);
    rel_also = 1'b0;

    @(negedge clk);
    sel = 1'b0; target = 2'd0; tx_data = 8'hE7;
    cs_hold = 1'b0; miso_mode = 2'd0; tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    rises = 0; prev = 1'b0;
    for (int n = 0; n < 40 && rises < 4; n++) begin
      @(negedge clk);
      if (sck && !prev) rises++;
      prev = sck;
    end
    check("rst_mid_rises", rises, 4);
    rst = 1'b1;
    @(negedge clk);
    check("abort_sck", int'(sck), 0);
    check("abort_cs", int'(csn), 15);
    check("abort_rxv", int'(rxv), 0);
    check("abort_ready", int'(rdy), 1);
    check("abort_busy", int'(bsy), 0);
    check("abort_rxd", int'(rxd), 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_idle_ready", int'(rdy), 1);
    check("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_n, err_n);
    $finish;
  end
endmodule

// File: doc/mist_spi_master.md
MIST_SPI_MASTER -- requirements
Module: mist_spi_master

Interface
REQ-001 SHALL have parameter CLKDIV, default 2, meaning SCK half-period in CLOCK_50 cycles; legal range 1..255.
REQ-002 SHALL have port CLOCK_50, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port RESET, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port tx_data, input, 8, byte to send, MSB first.
REQ-005 SHALL have port tx_valid, input, 1, byte request.
REQ-006 SHALL have port tx_ready, output, 1, request accepted when tx_valid and tx_ready are both high.
REQ-007 SHALL have port target, input, 2, target select sampled on accept: 00=CONF_DATA0 (user_io), 01=SPI_SS2 (data_io), 10=SPI_SS3 (OSD), 11=SPI_SS4.
REQ-008 SHALL have port cs_hold, input, 1, sampled on accept; when 1, the select stays asserted after the byte.
REQ-009 SHALL have port cs_release, input, 1, pulse that drops a held select without a transfer.
REQ-010 SHALL have port rx_data, output, 8, byte shifted in from SPI_DO.
REQ-011 SHALL have port rx_valid, output, 1, one-cycle pulse when rx_data is updated.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have ports SPI_SCK out 1, SPI_DI out 1 (MOSI), and SPI_DO in 1 (MISO).
REQ-014 SHALL have ports CONF_DATA0, SPI_SS2, SPI_SS3 and SPI_SS4, each output, 1, active-low select.

Function
REQ-015 SHALL implement SPI mode 0: SCK idles low, MOSI changes while SCK is low, SPI_DO is sampled on the SCK rising edge.
REQ-016 SHALL use FSM states IDLE, SHIFT_LO, SHIFT_HI, GAP.
- IDLE -> SHIFT_LO on accept.
- SHIFT_LO -> SHIFT_HI after CLKDIV cycles.
- SHIFT_HI -> SHIFT_LO after CLKDIV cycles while bits remain.
- After the 8th SHIFT_HI: go to GAP if cs_hold=0, else to IDLE.
- GAP -> IDLE after CLKDIV cycles.
REQ-017 SHALL be timed from the accept cycle T:
- the selected CS goes low and SPI_DI=tx_data[7] at T+1;
- the k-th SCK rise is at T+1+(2k-1)*CLKDIV;
- the 8th fall is at T+1+16*CLKDIV.
REQ-018 SHALL pulse rx_valid and update rx_data in the cycle of the 8th SCK fall; tx_ready is high that same cycle only if cs_hold=1.
REQ-019 SHALL assert tx_ready only in IDLE.
REQ-020 SHALL deassert all selects throughout GAP, so the minimum deselect time is CLKDIV cycles.
REQ-021 SHALL handle an accept while a select is held and target differs from the held target: release the old select, run GAP, then start the byte; tx_ready stays low during this.
REQ-022 SHALL handle an accept while a select is held and target equals the held target: start the byte with no deselect.
REQ-023 SHALL handle cs_release in IDLE with a held select by entering GAP; cs_release is ignored in all other states.
REQ-024 SHALL give tx_valid priority over cs_release when both are high in IDLE.
REQ-025 SHALL never assert more than one select simultaneously.
REQ-026 SHALL use an 8-bit half-period counter and a 3-bit bit counter; with CLKDIV=1, SCK toggles every cycle.

Reset
REQ-027 SHALL, on RESET high at a clock edge, set: FSM=IDLE, SPI_SCK=0, SPI_DI=0, all selects=1, rx_data=0x00, rx_valid=0, busy=0, tx_ready=1 from the next cycle.
REQ-028 SHALL, when RESET occurs mid-byte, abort immediately with no rx_valid and no GAP.

Configuration
REQ-029 SHALL use macro MIST_SPI_MASTER_SS4_EN.
- Defined: port SPI_SS4 exists, and target=11 drives it.
- Undefined: port SPI_SS4 is absent, and target=11 clocks the byte with no select asserted (dummy clocks); rx_valid still pulses.

Verification
REQ-030 SHALL test: CLKDIV=2, target=00, tx_data=0xA5, SPI_DO looped to SPI_DI -> CONF_DATA0 low at T+1, 8 SCK rises, rx_data=0xA5 with rx_valid at T+33, CONF_DATA0 high T+33..T+34.
REQ-031 SHALL test: two bytes 0x12, 0x34 to target=01, first with cs_hold=1 -> SPI_SS2 continuously low across both, no GAP between them.
REQ-032 SHALL test: held SPI_SS3, then accept to target=01 -> SPI_SS3 high, 2-cycle GAP, then SPI_SS2 low; never both low.
REQ-033 SHALL test: RESET asserted at the 4th SCK rise -> next cycle SCK=0, all selects high, no rx_valid, tx_ready=1.
REQ-034 SHALL test: CLKDIV=1, SPI_DO tied 1 -> rx_data=0xFF at T+17.
REQ-035 SHALL test: MIST_SPI_MASTER_SS4_EN undefined, target=11 -> no select low, 8 clocks, rx_valid pulses.
